// File: rtl/fetch_predict_if.sv
// Fetch-to-pipeline bus: instruction memory port, f2d payload, branch
// resolution from execute, and the flush/statistics outputs.
//   master : fetch stage (drives PC/instr/history/flush/counter)
//   slave  : environment (hazard unit, imem, execute)
interface fetch_predict_if;
  localparam int unsigned PC_W = 16;

  logic            stall;
  logic [PC_W-1:0] imem_addr_16;
  logic [PC_W-1:0] imem_rdata_16;
  logic [PC_W-1:0] instr_f_16;
  logic [PC_W-1:0] pc_f_16;
  logic            history_f;
  logic            resolve_valid;
  logic [PC_W-1:0] resolve_pc_16;
  logic            resolve_taken;
  logic            resolve_pred;
  logic [PC_W-1:0] resolve_target_16;
  logic            flush_f2d;
  logic [PC_W-1:0] mispredict_cnt_16;

  modport master (
    input  stall, imem_rdata_16,
    input  resolve_valid, resolve_pc_16, resolve_taken, resolve_pred, resolve_target_16,
    output imem_addr_16, instr_f_16, pc_f_16, history_f, flush_f2d, mispredict_cnt_16
  );

  modport slave (
    output stall, imem_rdata_16,
    output resolve_valid, resolve_pc_16, resolve_taken, resolve_pred, resolve_target_16,
    input  imem_addr_16, instr_f_16, pc_f_16, history_f, flush_f2d, mispredict_cnt_16
  );
endinterface

// File: rtl/fetch_predict.sv
// Fetch stage: PC generation with a 2-bit-counter BHT and tagged BTB,
// mispredict redirect/flush and a saturating mispredict counter.
// Ports:
//   clk   : clock, all state on posedge
//   clr_n : synchronous active-low reset
//   bus   : fetch_predict_if.master (stall, imem port, f2d payload,
//           branch resolution, flush_f2d, mispredict_cnt_16)
module fetch_predict #(
  parameter int unsigned IDX_W    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic           clk,
  input  logic           clr_n,
  fetch_predict_if.master bus
);
  localparam int unsigned PC_W  = 16;
  localparam int unsigned TAG_W = PC_W - IDX_W;
  localparam int unsigned DEPTH = 1 << IDX_W;
  localparam logic [PC_W-1:0] CNT_MAX = '1;

  logic [PC_W-1:0]  pc_reg;
  logic [PC_W-1:0]  cnt_reg;
  logic [1:0]       bht [DEPTH];
  logic [DEPTH-1:0] btb_valid;
  logic [TAG_W-1:0] btb_tag [DEPTH];
  logic [PC_W-1:0]  btb_target [DEPTH];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             hit;
  logic             pred_taken;
  logic [PC_W-1:0]  next_pred;
  logic             mispred;
  logic [PC_W-1:0]  redirect_pc;
  logic [IDX_W-1:0] ridx;
  logic [1:0]       bht_next;

  // Prediction from current PC using pre-update table contents
  always_comb begin
    idx        = pc_reg[IDX_W-1:0];
    tag        = pc_reg[PC_W-1:IDX_W];
    hit        = btb_valid[idx] && (btb_tag[idx] == tag);
    pred_taken = hit && bht[idx][1];
    next_pred  = pred_taken ? btb_target[idx] : pc_reg + PC_W'(1);
  end

  // Resolution: mispredict detect, redirect target, saturating counter step
  always_comb begin
    mispred     = bus.resolve_valid && (bus.resolve_taken ^ bus.resolve_pred);
    redirect_pc = bus.resolve_taken ? bus.resolve_target_16 : bus.resolve_pc_16 + PC_W'(1);
    ridx        = bus.resolve_pc_16[IDX_W-1:0];
    bht_next    = bht[ridx];
    if (bus.resolve_taken) begin
      if (bht[ridx] != 2'b11) bht_next = bht[ridx] + 2'd1;
    end else begin
      if (bht[ridx] != 2'b00) bht_next = bht[ridx] - 2'd1;
    end
  end

  // PC, BHT, BTB valid bits and mispredict counter
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      pc_reg    <= RESET_PC;
      cnt_reg   <= '0;
      btb_valid <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) bht[IDX_W'(i)] <= 2'b01;
    end else begin
      // Redirect has priority over stall
      if (mispred)         pc_reg <= redirect_pc;
      else if (!bus.stall) pc_reg <= next_pred;
      if (mispred && (cnt_reg != CNT_MAX)) cnt_reg <= cnt_reg + PC_W'(1);
      if (bus.resolve_valid) begin
        bht[ridx] <= bht_next;
        // Not-taken never invalidates an entry
        if (bus.resolve_taken) btb_valid[ridx] <= 1'b1;
      end
    end
  end

  // BTB payload; guarded by valid so it needs no reset
  always_ff @(posedge clk) begin
    if (clr_n && bus.resolve_valid && bus.resolve_taken) begin
      btb_tag[ridx]    <= bus.resolve_pc_16[PC_W-1:IDX_W];
      btb_target[ridx] <= bus.resolve_target_16;
    end
  end

  assign bus.imem_addr_16      = pc_reg;
  assign bus.pc_f_16           = pc_reg;
  assign bus.instr_f_16        = bus.imem_rdata_16;
  assign bus.history_f         = pred_taken;
  assign bus.flush_f2d         = mispred;
  assign bus.mispredict_cnt_16 = cnt_reg;
endmodule

// File: tb/tb_fetch_predict.sv
// Bench for fetch_predict: directed vector table plus randomized resolves
// checked against a behavioural predictor model.
module tb_fetch_predict;
  logic clk = 1'b0;
  logic clr_n;
  always #5 clk = ~clk;

  fetch_predict_if bus();
  fetch_predict #(.IDX_W(4), .RESET_PC(16'h0000)) dut (
    .clk(clk), .clr_n(clr_n), .bus(bus)
  );

  // Instruction memory: combinational, content derived from address
  assign bus.imem_rdata_16 = bus.imem_addr_16 ^ 16'hA5C3;

  typedef struct {
    logic        clr_n, stall, rv;
    logic [15:0] rpc;
    logic        rt, rp;
    logic [15:0] rtgt;
    logic [15:0] e_pc;
    logic        e_hist, e_flush;
    logic [15:0] e_cnt;
  } vec_t;

  int checks = 0;
  int passes = 0;

  // Model: per-index counter 0..3, BTB remembers the full branch PC
  int          m_ctr [16];
  bit          m_bv  [16];
  logic [15:0] m_bp  [16];
  logic [15:0] m_bt  [16];
  logic [15:0] m_pc;
  int          m_cnt;
  bit          m_ok = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic vec_t mk(input logic c, input logic s, input logic rv,
                              input logic [15:0] rpc, input logic rt, input logic rp,
                              input logic [15:0] rtgt, input logic [15:0] epc,
                              input logic eh, input logic ef, input logic [15:0] ecnt);
    vec_t v;
    v.clr_n = c; v.stall = s; v.rv = rv; v.rpc = rpc; v.rt = rt; v.rp = rp;
    v.rtgt = rtgt; v.e_pc = epc; v.e_hist = eh; v.e_flush = ef; v.e_cnt = ecnt;
    return v;
  endfunction

  function automatic bit m_taken();
    int k;
    k = int'(m_pc) % 16;
    return m_bv[k] && (m_bp[k] == m_pc) && (m_ctr[k] >= 2);
  endfunction

  function automatic logic [15:0] tgt_of(input logic [15:0] p);
    return (p * 16'd5 + 16'd3) & 16'h003F;
  endfunction

  task automatic apply(input vec_t v);
    clr_n                 = v.clr_n;
    bus.stall             = v.stall;
    bus.resolve_valid     = v.rv;
    bus.resolve_pc_16     = v.rpc;
    bus.resolve_taken     = v.rt;
    bus.resolve_pred      = v.rp;
    bus.resolve_target_16 = v.rtgt;
  endtask

  // Check at negedge, advance the model, then step past the posedge
  task automatic run_cycle(input bit use_tbl, input vec_t v);
    bit          mis;
    bit          tk;
    logic [15:0] npc;
    int          r;
    @(negedge clk);
    mis = v.rv && (v.rt != v.rp);
    if (use_tbl) begin
      chk("tbl_pc",    bus.pc_f_16, v.e_pc);
      chk("tbl_instr", bus.instr_f_16, v.e_pc ^ 16'hA5C3);
      chk("tbl_hist",  {15'd0, bus.history_f}, {15'd0, v.e_hist});
      chk("tbl_flush", {15'd0, bus.flush_f2d}, {15'd0, v.e_flush});
      chk("tbl_cnt",   bus.mispredict_cnt_16, v.e_cnt);
    end
    if (m_ok) begin
      tk = m_taken();
      chk("mdl_pc",    bus.pc_f_16, m_pc);
      chk("mdl_addr",  bus.imem_addr_16, m_pc);
      chk("mdl_instr", bus.instr_f_16, m_pc ^ 16'hA5C3);
      chk("mdl_hist",  {15'd0, bus.history_f}, {15'd0, tk});
      chk("mdl_flush", {15'd0, bus.flush_f2d}, {15'd0, mis});
      chk("mdl_cnt",   bus.mispredict_cnt_16, 16'(m_cnt));
    end
    if (!v.clr_n) begin
      m_pc = 16'h0000;
      m_cnt = 0;
      for (int i = 0; i < 16; i++) begin m_ctr[i] = 1; m_bv[i] = 1'b0; end
      m_ok = 1'b1;
    end else if (m_ok) begin
      if (mis)          npc = v.rt ? v.rtgt : v.rpc + 16'd1;
      else if (v.stall) npc = m_pc;
      else              npc = m_taken() ? m_bt[int'(m_pc) % 16] : m_pc + 16'd1;
      if (v.rv) begin
        r = int'(v.rpc) % 16;
        if (v.rt) begin
          if (m_ctr[r] < 3) m_ctr[r]++;
          m_bv[r] = 1'b1; m_bp[r] = v.rpc; m_bt[r] = v.rtgt;
        end else if (m_ctr[r] > 0) begin
          m_ctr[r]--;
        end
      end
      if (mis && m_cnt < 65535) m_cnt++;
      m_pc = npc;
    end
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [32];
  vec_t v;

  initial begin
    // clr, stall, rv, rpc, taken, pred, target | pc, hist, flush, cnt
    tbl[0]  = mk(1,0,0,16'h0000,0,0,16'h0000, 16'h0000,0,0,16'd0);
    tbl[1]  = mk(1,0,0,16'h0000,0,0,16'h0000, 16'h0001,0,0,16'd0);
    tbl[2]  = mk(1,0,0,16'h0000,0,0,16'h0000, 16'h0002,0,0,16'd0);
    tbl[3]  = mk(1,0,0,16'h0000,0,0,16'h0000, 16'h0003,0,0,16'd0);
    tbl[4]  = mk(1,0,0,16'h0000,0,0,16'h0000, 16'h0004,0,0,16'd0);
    tbl[5]  = mk(1,1,0,16'h0000,0,0,16'h0000, 16'h0005,0,0,16'd0);
    tbl[6]  = mk(1,1,0,16'h0000,0,0,16'h0000, 16'h0005,0,0,16'd0);
    tbl[7]  = mk(1,1,0,16'h0000,0,0,16'h0000, 16'h0005,0,0,16'd0);
    tbl[8]  = mk(1,0,0,16'h0000,0,0,16'h0000, 16'h0005,0,0,16'd0);
    tbl[9]  = mk(1,0,0,16'h0000,0,0,16'h0000, 16'h0006,0,0,16'd0);
    tbl[10] = mk(1,0,0,16'h0000,0,0,16'h0000, 16'h0007,0,0,16'd0);
    tbl[11] = mk(1,1,1,16'h0008,1,0,16'h0020, 16'h0008,0,1,16'd0);
    tbl[12] = mk(1,0,0,16'h0000,0,0,16'h0000, 16'h0020,0,0,16'd1);
    tbl[13] = mk(1,0,1,16'h0007,0,1,16'h0000, 16'h0021,0,1,16'd1);
    tbl[14] = mk(1,0,0,16'h0000,0,0,16'h0000, 16'h0008,1,0,16'd2);
    tbl[15] = mk(1,0,1,16'h0008,1,1,16'h0020, 16'h0020,0,0,16'd2);
    tbl[16] = mk(1,0,1,16'h0008,1,1,16'h0020, 16'h0021,0,0,16'd2);
    tbl[17] = mk(1,0,1,16'h0008,1,1,16'h0020, 16'h0022,0,0,16'd2);
    tbl[18] = mk(1,0,1,16'h0008,0,1,16'h0020, 16'h0023,0,1,16'd2);
    tbl[19] = mk(1,0,0,16'h0000,0,0,16'h0000, 16'h0009,0,0,16'd3);
    tbl[20] = mk(1,0,1,16'h0007,0,1,16'h0000, 16'h000A,0,1,16'd3);
    tbl[21] = mk(1,0,0,16'h0000,0,0,16'h0000, 16'h0008,1,0,16'd4);
    tbl[22] = mk(1,0,1,16'h0017,0,1,16'h0000, 16'h0020,0,1,16'd4);
    tbl[23] = mk(1,0,0,16'h0000,0,0,16'h0000, 16'h0018,0,0,16'd5);
    tbl[24] = mk(1,0,0,16'h0000,0,0,16'h0000, 16'h0019,0,0,16'd5);
    tbl[25] = mk(1,0,1,16'h0100,1,0,16'hFFFF, 16'h001A,0,1,16'd5);
    tbl[26] = mk(1,0,0,16'h0000,0,0,16'h0000, 16'hFFFF,0,0,16'd6);
    tbl[27] = mk(1,0,0,16'h0000,0,0,16'h0000, 16'h0000,0,0,16'd6);
    tbl[28] = mk(0,0,1,16'h0030,1,0,16'h0040, 16'h0001,0,1,16'd6);
    tbl[29] = mk(1,0,0,16'h0000,0,0,16'h0000, 16'h0000,0,0,16'd0);
    tbl[30] = mk(1,0,1,16'h0007,0,1,16'h0000, 16'h0001,0,1,16'd0);
    tbl[31] = mk(1,0,0,16'h0000,0,0,16'h0000, 16'h0008,0,0,16'd1);

    // Reset for two cycles, then check the reset state with clr_n still low
    v = mk(0,0,0,16'h0000,0,0,16'h0000, 16'h0000,0,0,16'd0);
    apply(v);
    run_cycle(1'b0, v);
    run_cycle(1'b0, v);
    chk("rst_pc",    bus.pc_f_16, 16'h0000);
    chk("rst_addr",  bus.imem_addr_16, 16'h0000);
    chk("rst_hist",  {15'd0, bus.history_f}, 16'd0);
    chk("rst_flush", {15'd0, bus.flush_f2d}, 16'd0);
    chk("rst_cnt",   bus.mispredict_cnt_16, 16'd0);

    for (int i = 0; i < 32; i++) begin
      apply(tbl[i]);
      run_cycle(1'b1, tbl[i]);
    end

    // Randomized traffic confined mostly to a small PC window to get BTB hits
    for (int n = 0; n < 600; n++) begin
      v = mk(1,0,0,16'h0000,0,0,16'h0000, 16'h0000,0,0,16'd0);
      v.clr_n = ($urandom_range(0, 59) != 0);
      v.stall = ($urandom_range(0, 3) == 0);
      v.rv    = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) v.rpc = 16'($urandom);
      else                           v.rpc = 16'($urandom_range(0, 63));
      v.rt   = 1'($urandom_range(0, 1));
      v.rp   = ($urandom_range(0, 3) == 0) ? ~v.rt : v.rt;
      v.rtgt = tgt_of(v.rpc);
      apply(v);
      run_cycle(1'b0, v);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
